bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
Parametrised bus arbiter; successor to the fixed 8-bit one-hot priority generator. Grants one master the shared bus from NUM_MASTERS request lines, in either fixed-priority or round-robin mode. The grant is held while the owner keeps requesting, and a hold-limit timer stops one master from starving the rest. Sits between the master request lines and the bus mux/select logic.

Parameters:
NUM_MASTERS, 8, number of requesters (2..32)
ROUND_ROBIN, 1, 0 = fixed priority (index 0 highest), 1 = rotating priority
MAX_HOLD, 16, max consecutive BUSY cycles before forced handover when others wait; 0 disables timeout
IDX_W, $clog2(NUM_MASTERS), derived, width of grant_idx (local, not overridable)

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
en  in  1  arbiter enable; 0 freezes all state and outputs
req  in  NUM_MASTERS  request per master, level, held until done
grant  out  NUM_MASTERS  registered one-hot grant, all-zero when bus idle
grant_idx  out  IDX_W  binary index of grant; valid only when grant_valid=1
grant_valid  out  1  high while any grant bit is set
timeout  out  1  one-cycle pulse on the edge a forced handover occurs

Behaviour:
- Reset (async, reset_n=0): grant=0, grant_idx=0, grant_valid=0, timeout=0, state=IDLE, hold_cnt=0, last_idx=NUM_MASTERS-1. Deassertion takes effect at the next clk edge.
- en=0: every register holds its value, timeout forced to 0. Request changes during en=0 are evaluated only on the first enabled edge.
- Winner selection is combinational from a candidate mask:
  - Fixed mode: lowest set index wins.
  - RR mode: first set index searching upward from last_idx+1, wrapping at NUM_MASTERS-1 to 0.
  - No candidate: no winner.
- States: IDLE, BUSY.
- IDLE, any req: on the next edge grant=onehot(winner), grant_idx=winner, grant_valid=1, last_idx=winner, hold_cnt=0, state=BUSY. Latency from req rise to grant is 1 cycle.
- IDLE, no req: outputs stay 0.
- BUSY, req[owner]=1, below limit: grant unchanged, hold_cnt+1 (saturating).
- BUSY, req[owner]=0 (release): re-arbitrate on the same edge with candidates = req & ~onehot(owner).
  - Winner exists: direct handover, no idle cycle.
  - No winner: grant=0, grant_valid=0, state=IDLE.
  - hold_cnt=0 in both cases.
- BUSY, MAX_HOLD>0, hold_cnt==MAX_HOLD-1, owner still requesting:
  - Other masters requesting: forced handover to the winner of req & ~owner, timeout=1 for that cycle, hold_cnt=0.
  - No other requesters: owner keeps the bus, hold_cnt stays saturated, no pulse. A later arriving request triggers the handover on the next edge.
- Fixed mode handover excludes only the current owner, so a timed-out master 0 is passed over once and regains the bus at the next arbitration.
- grant is always one-hot or zero; grant_idx keeps its last value when grant_valid=0.
- hold_cnt width: $clog2(MAX_HOLD+1), minimum 1.
- Reset asserted mid-BUSY: grant drops immediately (asynchronously), RR pointer returns to NUM_MASTERS-1.

Decomposition:
- Package bus_arb_pkg holds:
  - state enum {IDLE, BUSY}
  - mode constants ARB_FIXED=0, ARB_RR=1
  - clog2-with-minimum-1 helper function
- One sub-module, arb_pick: purely combinational.
  - Inputs: candidate mask, start index, mode.
  - Outputs: one-hot winner, binary index, found flag.
  - Instantiated once; all selection goes through it.

Test Plan:
- Reset then req=8'b0000_0110, fixed mode -> one cycle later grant=8'b0000_0010, grant_idx=1, grant_valid=1.
- RR mode, req=8'hFF held, each owner drops req for 1 cycle after 2 cycles -> grant_idx sequence 0,1,2,...,7,0.
- MAX_HOLD=4, master 3 holds req, master 5 requests from cycle 1 -> grant switches 3->5 after 4 BUSY cycles, timeout pulses exactly once.
- MAX_HOLD=4, only master 2 requesting for 10 cycles -> grant stays 8'b0000_0100, timeout never asserts.
- Owner 0 releases while req=8'b1000_0000 -> next edge grant=8'b1000_0000, no cycle with grant_valid=0.
- en=0 for 3 cycles while req changes, then reset_n pulsed low mid-BUSY -> outputs frozen during en=0, then grant=0 asynchronously on reset.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// ---------------------------------------------------------------------------
// bus_arb_pkg
// Shared types and helpers for the bus arbiter.
//   state_t    : arbiter FSM states
//   ARB_FIXED  : fixed priority selection (index 0 highest)
//   ARB_RR     : rotating priority selection
//   clog2_min1 : ceil(log2(value)), never less than 1 bit
// ---------------------------------------------------------------------------
package bus_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic ARB_FIXED = 1'b0;
  localparam logic ARB_RR    = 1'b1;

  function automatic int clog2_min1(input int value);
    int w;
    w = $clog2(value);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/bus_arbiter_pick.sv
// ---------------------------------------------------------------------------
// arb_pick
// Combinational winner selection over a candidate mask.
// Ports:
//   i_cand   in  N  candidate mask
//   i_start  in  W  first index searched (rotating mode only)
//   i_mode   in  1  ARB_FIXED or ARB_RR
//   o_onehot out N  one-hot winner, zero when no candidate
//   o_idx    out W  binary winner index, zero when no candidate
//   o_found  out 1  a candidate exists
// ---------------------------------------------------------------------------
module arb_pick
  import bus_arb_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] i_cand,
  input  logic [W-1:0] i_start,
  input  logic         i_mode,
  output logic [N-1:0] o_onehot,
  output logic [W-1:0] o_idx,
  output logic         o_found
);

  always_comb begin
    int base;
    int j;
    o_onehot = '0;
    o_idx    = '0;
    o_found  = 1'b0;
    base     = (i_mode == ARB_RR) ? int'(i_start) : 0;
    j        = 0;
    // Walk every position once starting at base, wrapping past N-1 to 0.
    for (int i = 0; i < N; i++) begin
      j = base + i;
      if (j >= N) j = j - N;
      if (!o_found && i_cand[j]) begin
        o_found     = 1'b1;
        o_idx       = W'(j);
        o_onehot[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
// Grants one of NUM_MASTERS requesters the shared bus, fixed or rotating
// priority. The owner keeps the bus while requesting; a hold-limit timer
// forces a handover after MAX_HOLD busy cycles when others are waiting.
//
// state | meaning
// IDLE  | no owner, grant all-zero
// BUSY  | one master owns the bus, hold timer running
//
// Ports:
//   clk          in  1      rising-edge clock
//   reset_n      in  1      asynchronous active-low reset
//   en           in  1      enable; 0 freezes all state, timeout forced low
//   req          in  N      level request per master
//   grant        out N      registered one-hot grant, zero when idle
//   grant_idx    out IDX_W  binary index of grant, holds when idle
//   grant_valid  out 1      any grant bit set
//   timeout      out 1      one-cycle pulse on a forced handover
// ---------------------------------------------------------------------------
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter  int NUM_MASTERS = 8,
  parameter  int ROUND_ROBIN = 1,
  parameter  int MAX_HOLD    = 16,
  localparam int IDX_W       = $clog2(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   en,
  input  logic [NUM_MASTERS-1:0] req,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [IDX_W-1:0]       grant_idx,
  output logic                   grant_valid,
  output logic                   timeout
);

  localparam int               HOLD_W    = clog2_min1(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_MASTERS - 1);
  localparam logic              MODE      = (ROUND_ROBIN != 0) ? ARB_RR : ARB_FIXED;

  state_t                 r_state;
  logic [NUM_MASTERS-1:0] r_grant;
  logic [IDX_W-1:0]       r_grant_idx;
  logic [IDX_W-1:0]       r_last_idx;
  logic [HOLD_W-1:0]      r_hold_cnt;
  logic                   r_timeout;

  state_t                 w_nxt_state;
  logic [NUM_MASTERS-1:0] w_nxt_grant;
  logic [IDX_W-1:0]       w_nxt_grant_idx;
  logic [IDX_W-1:0]       w_nxt_last_idx;
  logic [HOLD_W-1:0]      w_nxt_hold_cnt;
  logic                   w_nxt_timeout;

  logic [NUM_MASTERS-1:0] w_cand;
  logic [IDX_W-1:0]       w_start;
  logic [NUM_MASTERS-1:0] w_win_onehot;
  logic [IDX_W-1:0]       w_win_idx;
  logic                   w_win_found;
  logic                   w_owner_req;

  // While busy the owner is never a candidate: the pick is only used for a
  // release or a forced handover, both of which must move the bus away.
  assign w_cand      = (r_state == BUSY) ? (req & ~r_grant) : req;
  assign w_start     = (r_last_idx == LAST_IDX) ? '0 : (r_last_idx + 1'b1);
  assign w_owner_req = |(req & r_grant);

  arb_pick #(
    .N (NUM_MASTERS)
  ) u_pick (
    .i_cand   (w_cand),
    .i_start  (w_start),
    .i_mode   (MODE),
    .o_onehot (w_win_onehot),
    .o_idx    (w_win_idx),
    .o_found  (w_win_found)
  );

  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_grant     = r_grant;
    w_nxt_grant_idx = r_grant_idx;
    w_nxt_last_idx  = r_last_idx;
    w_nxt_hold_cnt  = r_hold_cnt;
    w_nxt_timeout   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_win_found) begin
          w_nxt_state     = BUSY;
          w_nxt_grant     = w_win_onehot;
          w_nxt_grant_idx = w_win_idx;
          w_nxt_last_idx  = w_win_idx;
          w_nxt_hold_cnt  = '0;
        end
      end
      BUSY: begin
        if (!w_owner_req) begin
          w_nxt_hold_cnt = '0;
          if (w_win_found) begin
            w_nxt_grant     = w_win_onehot;
            w_nxt_grant_idx = w_win_idx;
            w_nxt_last_idx  = w_win_idx;
          end else begin
            w_nxt_state = IDLE;
            w_nxt_grant = '0;
          end
        end else if ((MAX_HOLD > 0) && (r_hold_cnt == HOLD_LAST)) begin
          // At the limit with nobody waiting the owner keeps the bus and the
          // counter stays parked here, so a late requester wins next edge.
          if (w_win_found) begin
            w_nxt_grant     = w_win_onehot;
            w_nxt_grant_idx = w_win_idx;
            w_nxt_last_idx  = w_win_idx;
            w_nxt_hold_cnt  = '0;
            w_nxt_timeout   = 1'b1;
          end
        end else if (r_hold_cnt != '1) begin
          w_nxt_hold_cnt = r_hold_cnt + 1'b1;
        end
      end
      default: begin
        w_nxt_state = IDLE;
        w_nxt_grant = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_grant_idx <= '0;
      r_last_idx  <= LAST_IDX;
      r_hold_cnt  <= '0;
      r_timeout   <= 1'b0;
    end else if (en) begin
      r_state     <= w_nxt_state;
      r_grant     <= w_nxt_grant;
      r_grant_idx <= w_nxt_grant_idx;
      r_last_idx  <= w_nxt_last_idx;
      r_hold_cnt  <= w_nxt_hold_cnt;
      r_timeout   <= w_nxt_timeout;
    end else begin
      r_timeout   <= 1'b0;
    end
  end

  assign grant       = r_grant;
  assign grant_idx   = r_grant_idx;
  assign grant_valid = |r_grant;
  // Gate so a pulse registered just before en falls is not seen while frozen.
  assign timeout     = r_timeout & en;

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

  logic       clk;
  logic       reset_n;

  logic       fx_en;
  logic [7:0] fx_req;
  logic [7:0] fx_grant;
  logic [2:0] fx_grant_idx;
  logic       fx_grant_valid;
  logic       fx_timeout;

  logic       rr_en;
  logic [7:0] rr_req;
  logic [7:0] rr_grant;
  logic [2:0] rr_grant_idx;
  logic       rr_grant_valid;
  logic       rr_timeout;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  bus_arbiter #(
    .NUM_MASTERS (8),
    .ROUND_ROBIN (0),
    .MAX_HOLD    (4)
  ) u_fx (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (fx_en),
    .req         (fx_req),
    .grant       (fx_grant),
    .grant_idx   (fx_grant_idx),
    .grant_valid (fx_grant_valid),
    .timeout     (fx_timeout)
  );

  bus_arbiter #(
    .NUM_MASTERS (8),
    .ROUND_ROBIN (1),
    .MAX_HOLD    (4)
  ) u_rr (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (rr_en),
    .req         (rr_req),
    .grant       (rr_grant),
    .grant_idx   (rr_grant_idx),
    .grant_valid (rr_grant_valid),
    .timeout     (rr_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    fx_en   = 1'b1;
    rr_en   = 1'b1;
    fx_req  = 8'h00;
    rr_req  = 8'h00;
    #2;
    chk("rst_grant",   fx_grant, 8'h00);
    chk("rst_idx",     fx_grant_idx, 3'd0);
    chk("rst_valid",   fx_grant_valid, 1'b0);
    chk("rst_timeout", fx_timeout, 1'b0);
    chk("rst_rr_grant", rr_grant, 8'h00);
    tick();
    reset_n = 1'b1;
    tick();
    chk("idle_no_req", fx_grant_valid, 1'b0);

    // Rotating priority: each owner holds two cycles, drops for one.
    rr_req = 8'hFF;
    tick();
    for (int k = 0; k < 8; k++) begin
      chk("rr_idx_grant", rr_grant_idx, k);
      tick();
      chk("rr_idx_hold", rr_grant_idx, k);
      rr_req = 8'hFF & ~(8'h01 << k);
      tick();
      rr_req = 8'hFF;
      chk("rr_valid_handover", rr_grant_valid, 1'b1);
    end
    chk("rr_wrap_idx", rr_grant_idx, 3'd0);
    chk("rr_wrap_grant", rr_grant, 8'h01);
    rr_req = 8'h00;
    tick();
    chk("rr_idle_valid", rr_grant_valid, 1'b0);
    chk("rr_idle_idx_kept", rr_grant_idx, 3'd0);

    // Fixed priority basic grant, then release to idle.
    fx_req = 8'b0000_0110;
    tick();
    chk("fx_grant", fx_grant, 8'b0000_0010);
    chk("fx_idx", fx_grant_idx, 3'd1);
    chk("fx_valid", fx_grant_valid, 1'b1);
    fx_req = 8'h00;
    tick();
    chk("fx_rel_grant", fx_grant, 8'h00);
    chk("fx_rel_valid", fx_grant_valid, 1'b0);
    chk("fx_rel_idx_kept", fx_grant_idx, 3'd1);

    // Hold limit: master 3 owns, master 5 waits, handover after 4 busy cycles.
    fx_req = 8'b0000_1000;
    tick();
    chk("to_own3", fx_grant, 8'b0000_1000);
    fx_req = 8'b0010_1000;
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("to_hold3", fx_grant, 8'b0000_1000);
      chk("to_nopulse", fx_timeout, 1'b0);
    end
    tick();
    chk("to_grant5", fx_grant, 8'b0010_0000);
    chk("to_idx5", fx_grant_idx, 3'd5);
    chk("to_pulse", fx_timeout, 1'b1);
    tick();
    chk("to_pulse_end", fx_timeout, 1'b0);
    chk("to_keep5", fx_grant, 8'b0010_0000);
    fx_req = 8'b0000_1000;
    tick();
    chk("to_regain3", fx_grant, 8'b0000_1000);
    chk("to_regain_valid", fx_grant_valid, 1'b1);

    // Lone requester past the limit keeps the bus with no pulse.
    fx_req = 8'b0000_0100;
    tick();
    chk("solo_grant", fx_grant, 8'b0000_0100);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("solo_hold", fx_grant, 8'b0000_0100);
      chk("solo_nopulse", fx_timeout, 1'b0);
    end
    // Late arrival hands over on the very next edge.
    fx_req = 8'b0000_0101;
    tick();
    chk("late_grant0", fx_grant, 8'b0000_0001);
    chk("late_pulse", fx_timeout, 1'b1);
    fx_en = 1'b0;
    #1;
    chk("pulse_gated_by_en", fx_timeout, 1'b0);
    fx_en = 1'b1;

    // Owner 0 releases with only master 7 waiting: direct handover.
    fx_req = 8'b1000_0000;
    tick();
    chk("rel_grant7", fx_grant, 8'b1000_0000);
    chk("rel_valid", fx_grant_valid, 1'b1);
    chk("rel_idx7", fx_grant_idx, 3'd7);
    chk("rel_nopulse", fx_timeout, 1'b0);

    // Freeze: requests move while disabled, nothing changes.
    fx_en  = 1'b0;
    fx_req = 8'h01;
    tick();
    chk("frz_grant_a", fx_grant, 8'b1000_0000);
    chk("frz_idx_a", fx_grant_idx, 3'd7);
    chk("frz_valid_a", fx_grant_valid, 1'b1);
    chk("frz_timeout_a", fx_timeout, 1'b0);
    fx_req = 8'h00;
    tick();
    chk("frz_grant_b", fx_grant, 8'b1000_0000);
    fx_req = 8'h03;
    tick();
    chk("frz_grant_c", fx_grant, 8'b1000_0000);
    fx_en = 1'b1;
    tick();
    chk("unfrz_grant", fx_grant, 8'b0000_0001);
    chk("unfrz_idx", fx_grant_idx, 3'd0);

    // Asynchronous reset mid-busy, then RR pointer must restart at 0.
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_grant", fx_grant, 8'h00);
    chk("arst_valid", fx_grant_valid, 1'b0);
    chk("arst_idx", fx_grant_idx, 3'd0);
    rr_req = 8'b1000_0001;
    tick();
    chk("arst_hold_grant", fx_grant, 8'h00);
    chk("arst_rr_grant", rr_grant, 8'h00);
    reset_n = 1'b1;
    tick();
    chk("rr_ptr_reset_grant", rr_grant, 8'b0000_0001);
    chk("rr_ptr_reset_idx", rr_grant_idx, 3'd0);
    chk("fx_after_rst", fx_grant_valid, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
